// File: rtl/prco_decoder_pipe_if.sv
// Fetch/execute-facing bundle of the PRCO decoder pipe.
// slave = decoder side; master = fetch driver and execute consumer side.
interface prco_decoder_pipe_if #(
  parameter int INSTR_W = 16,
  parameter int OP_W    = 5,
  parameter int SEL_W   = 3,
  parameter int DATA_W  = 16,
  parameter int CNT_W   = 8
);
  // Handshakes: an instruction moves on i_valid && q_ready, a decoded entry
  // moves on q_valid && i_ready; neither side may make its valid depend on ready.
  logic               i_flush;
  logic               i_valid;
  logic [INSTR_W-1:0] i_instr;
  logic               q_ready;
  logic               q_valid;
  logic               i_ready;
  logic [OP_W-1:0]    q_op;
  logic [SEL_W-1:0]   q_seld;
  logic [SEL_W-1:0]   q_sela;
  logic [SEL_W-1:0]   q_selb;
  logic               q_third_sel;
  logic [DATA_W-1:0]  q_imm;
  logic [DATA_W-1:0]  q_simm;
  logic               q_reg_we;
  logic               q_req_alu;
  logic               q_req_ram;
  logic               q_req_ram_we;
  logic               q_new_uart1_data;
  logic               q_branch;
  logic               q_illegal;
  logic [CNT_W-1:0]   q_illegal_cnt;

  modport slave (
    input  i_flush, i_valid, i_instr, i_ready,
    output q_ready, q_valid, q_op, q_seld, q_sela, q_selb, q_third_sel,
           q_imm, q_simm, q_reg_we, q_req_alu, q_req_ram, q_req_ram_we,
           q_new_uart1_data, q_branch, q_illegal, q_illegal_cnt
  );

  modport master (
    output i_flush, i_valid, i_instr, i_ready,
    input  q_ready, q_valid, q_op, q_seld, q_sela, q_selb, q_third_sel,
           q_imm, q_simm, q_reg_we, q_req_alu, q_req_ram, q_req_ram_we,
           q_new_uart1_data, q_branch, q_illegal, q_illegal_cnt
  );
endinterface

// File: rtl/prco_decoder_pipe.sv
// Elastic PRCO instruction decoder: combinational decode into a DEPTH-entry
// FIFO, with flush, optional NOP dropping and a saturating illegal-opcode counter.
module prco_decoder_pipe #(
  parameter int                   INSTR_W        = 16,
  parameter int                   OP_W           = 5,
  parameter int                   SEL_W          = 3,
  parameter int                   DATA_W         = 16,
  parameter int                   DEPTH          = 2,
  parameter int                   DROP_NOP       = 0,
  parameter logic [2**OP_W-1:0]   THIRD_SEL_MASK = '0,
  parameter int                   CNT_W          = 8
) (
  input logic               i_clk,
  input logic               i_reset,
  prco_decoder_pipe_if.slave bus
);

  localparam int IMM_W  = INSTR_W - OP_W - SEL_W;
  localparam int SIMM_W = IMM_W - SEL_W;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FILL_W = $clog2(DEPTH + 1);

  // PRCO opcode map
  localparam logic [OP_W-1:0] OP_NOP   = OP_W'(0);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_MOV   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_MOVI  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_CMP   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(7);
  localparam logic [OP_W-1:0] OP_JMP   = OP_W'(8);
  localparam logic [OP_W-1:0] OP_WRITE = OP_W'(9);

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [SEL_W-1:0]  seld;
    logic [SEL_W-1:0]  sela;
    logic [SEL_W-1:0]  selb;
    logic              third_sel;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] simm;
    logic              reg_we;
    logic              req_alu;
    logic              req_ram;
    logic              req_ram_we;
    logic              new_uart1_data;
    logic              branch;
    logic              illegal;
  } entry_t;

  logic [OP_W-1:0]  op;
  logic [IMM_W-1:0] imm_f;
  entry_t           dec;
  entry_t           head;
  entry_t           shown;
  entry_t           mem [DEPTH];

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [FILL_W-1:0] count;
  logic [CNT_W-1:0]  illegal_cnt;

  logic ready;
  logic valid;
  logic accept;
  logic drop;
  logic push;
  logic pop;

  assign op    = bus.i_instr[INSTR_W-1 -: OP_W];
  assign imm_f = bus.i_instr[IMM_W-1:0];

  always_comb begin
    dec                = '0;
    dec.op             = op;
    dec.seld           = bus.i_instr[INSTR_W-OP_W-1 -: SEL_W];
    dec.sela           = imm_f[IMM_W-1 -: SEL_W];
    dec.selb           = imm_f[IMM_W-SEL_W-1 -: SEL_W];
    dec.third_sel      = THIRD_SEL_MASK[op];
    dec.imm            = DATA_W'(imm_f);
    dec.simm           = DATA_W'($signed(imm_f[SIMM_W-1:0]));
    case (op)
      OP_NOP: ;
      OP_MOVI, OP_MOV, OP_ADD, OP_ADDI: begin
        dec.reg_we  = 1'b1;
        dec.req_alu = 1'b1;
      end
      OP_LW: begin
        dec.reg_we  = 1'b1;
        dec.req_ram = 1'b1;
      end
      OP_SW: begin
        dec.req_ram    = 1'b1;
        dec.req_ram_we = 1'b1;
      end
      OP_CMP:   dec.req_alu        = 1'b1;
      OP_JMP: begin
        dec.reg_we = 1'b1;
        dec.branch = 1'b1;
      end
      OP_WRITE: dec.new_uart1_data = 1'b1;
      default:  dec.illegal        = 1'b1;
    endcase
  end

  // No pass-through: a full FIFO refuses input even when the head pops this cycle.
  assign ready  = !i_reset && (count < FILL_W'(DEPTH));
  assign valid  = (count != '0);
  assign accept = bus.i_valid && ready;
  assign drop   = (DROP_NOP != 0) && (op == OP_NOP);
  assign push   = accept && !drop && !bus.i_flush;
  assign pop    = valid && bus.i_ready && !bus.i_flush;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      illegal_cnt <= '0;
    end else begin
      // The counter ignores flush so illegal fetches are never lost from the tally.
      if (accept && dec.illegal && (illegal_cnt != '1))
        illegal_cnt <= illegal_cnt + CNT_W'(1);
      if (bus.i_flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= next_ptr(wr_ptr);
        if (pop)  rd_ptr <= next_ptr(rd_ptr);
        case ({push, pop})
          2'b10:   count <= count + FILL_W'(1);
          2'b01:   count <= count - FILL_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= dec;
  end

  assign head  = mem[rd_ptr];
  assign shown = valid ? head : '0;

  assign bus.q_ready          = ready;
  assign bus.q_valid          = valid;
  assign bus.q_op             = shown.op;
  assign bus.q_seld           = shown.seld;
  assign bus.q_sela           = shown.sela;
  assign bus.q_selb           = shown.selb;
  assign bus.q_third_sel      = shown.third_sel;
  assign bus.q_imm            = shown.imm;
  assign bus.q_simm           = shown.simm;
  assign bus.q_reg_we         = shown.reg_we;
  assign bus.q_req_alu        = shown.req_alu;
  assign bus.q_req_ram        = shown.req_ram;
  assign bus.q_req_ram_we     = shown.req_ram_we;
  assign bus.q_new_uart1_data = shown.new_uart1_data;
  assign bus.q_branch         = shown.branch;
  assign bus.q_illegal        = shown.illegal;
  assign bus.q_illegal_cnt    = illegal_cnt;

endmodule
